// File: rtl/memshare_sched_ctrl.sv
// memshare_sched_ctrl
//   Sequencer for SCU.memShare(). It accepts one allocation request at a time
//   over a valid/ready handshake. It then runs SHIFT_GEN (one cycle), N
//   allocation pipeline cycles of PIPE_CYCLE_LEN clocks each, and a
//   DRAIN_LAT-cycle drain, and finally pulses done_o.
//
// Ports
//   sys_clk             : single clock
//   rst                 : synchronous active-high reset
//   rqst_valid_i        : request valid
//   rqst_ready_o        : controller idle, can accept a request
//   rqst_seq_num_i      : requested sequence count, sampled on accept (clamped to 1..MAX_SEQ)
//   stall_i             : downstream back-pressure, freezes ALLOC progress
//   abort_i             : synchronous abort of the current operation
//   scu_memShare_busy_o : high in SHIFT_GEN, ALLOC and DRAIN
//   rfmu_rd_o           : isGtr read strobe, high only in SHIFT_GEN
//   pipeCycle_begin_o   : first clock of each allocation pipeline cycle
//   seq_idx_o           : current sequence index in ALLOC, 0 elsewhere
//   last_seq_o          : ALLOC and seq_idx_o == N-1
//   done_o              : one-cycle completion pulse (first IDLE cycle after DRAIN)
module memshare_sched_ctrl #(
  parameter int MAX_SEQ        = 4,
  parameter int PIPE_CYCLE_LEN = 3,
  parameter int DRAIN_LAT      = 2,
  parameter int SEQ_W          = $clog2(MAX_SEQ + 1)
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             rqst_valid_i,
  output logic             rqst_ready_o,
  input  logic [SEQ_W-1:0] rqst_seq_num_i,
  input  logic             stall_i,
  input  logic             abort_i,
  output logic             scu_memShare_busy_o,
  output logic             rfmu_rd_o,
  output logic             pipeCycle_begin_o,
  output logic [SEQ_W-1:0] seq_idx_o,
  output logic             last_seq_o,
  output logic             done_o
);

  localparam int CYC_W = (PIPE_CYCLE_LEN > 1) ? $clog2(PIPE_CYCLE_LEN) : 1;
  localparam int DRN_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

  localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(PIPE_CYCLE_LEN - 1);
  localparam logic [DRN_W-1:0] DRN_ZERO = {DRN_W{1'b0}};
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_LAT - 1);
  localparam logic [SEQ_W-1:0] SEQ_ZERO = {SEQ_W{1'b0}};
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_MAX  = SEQ_W'(MAX_SEQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_GEN = 2'd1,
    ALLOC     = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] cyc, cyc_nx;
  logic [SEQ_W-1:0] seq, seq_nx;
  logic [DRN_W-1:0] drn, drn_nx;
  logic [SEQ_W-1:0] n_lat, n_nx;
  logic             done, done_nx;

  // Clamp a requested sequence count into the legal range 1..MAX_SEQ.
  function automatic logic [SEQ_W-1:0] clamp_seq(input logic [SEQ_W-1:0] req);
    logic [SEQ_W-1:0] r;
    if (req == SEQ_ZERO) begin
      r = SEQ_ONE;
    end else if (req > SEQ_MAX) begin
      r = SEQ_MAX;
    end else begin
      r = req;
    end
    return r;
  endfunction

  // State and counter registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= CYC_ZERO;
      seq   <= SEQ_ZERO;
      drn   <= DRN_ZERO;
      n_lat <= SEQ_ZERO;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
      seq   <= seq_nx;
      drn   <= drn_nx;
      n_lat <= n_nx;
      done  <= done_nx;
    end
  end

  // Next-state and counter update logic; abort outranks stall and normal flow.
  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    seq_nx   = seq;
    drn_nx   = drn;
    n_nx     = n_lat;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        // abort_i has no meaning while idle
        if (rqst_valid_i) begin
          state_nx = SHIFT_GEN;
          n_nx     = clamp_seq(rqst_seq_num_i);
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT_GEN: begin
        if (abort_i) begin
          state_nx = IDLE;
        end else begin
          state_nx = ALLOC;
        end
        cyc_nx = CYC_ZERO;
        seq_nx = SEQ_ZERO;
        drn_nx = DRN_ZERO;
      end
      ALLOC: begin
        if (abort_i) begin
          state_nx = IDLE;
          cyc_nx   = CYC_ZERO;
          seq_nx   = SEQ_ZERO;
          drn_nx   = DRN_ZERO;
        end else if (stall_i) begin
          state_nx = ALLOC;
        end else if (cyc == CYC_LAST) begin
          cyc_nx = CYC_ZERO;
          if (seq == (n_lat - SEQ_ONE)) begin
            state_nx = DRAIN;
            seq_nx   = SEQ_ZERO;
            drn_nx   = DRN_ZERO;
          end else begin
            seq_nx = seq + SEQ_ONE;
          end
        end else begin
          cyc_nx = cyc + CYC_ONE;
        end
      end
      DRAIN: begin
        // drain is a fixed flush and ignores back-pressure
        if (abort_i) begin
          state_nx = IDLE;
          cyc_nx   = CYC_ZERO;
          seq_nx   = SEQ_ZERO;
          drn_nx   = DRN_ZERO;
        end else if (drn == DRN_LAST) begin
          state_nx = IDLE;
          drn_nx   = DRN_ZERO;
          done_nx  = 1'b1;
        end else begin
          drn_nx = drn + DRN_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cyc_nx   = CYC_ZERO;
        seq_nx   = SEQ_ZERO;
        drn_nx   = DRN_ZERO;
      end
    endcase
  end

  // Outputs decode registered state; only pipeCycle_begin_o also looks at stall_i,
  // so a stalled first clock defers the pulse to the first unstalled clock.
  assign rqst_ready_o        = (state == IDLE);
  assign scu_memShare_busy_o = (state != IDLE);
  assign rfmu_rd_o           = (state == SHIFT_GEN);
  assign pipeCycle_begin_o   = (state == ALLOC) && (cyc == CYC_ZERO) && !stall_i;
  assign seq_idx_o           = (state == ALLOC) ? seq : SEQ_ZERO;
  assign last_seq_o          = (state == ALLOC) && (seq == (n_lat - SEQ_ONE));
  assign done_o              = done;

endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Directed bench for memshare_sched_ctrl. Each cycle pushes the expected
// output vector into a scoreboard queue and pops it when the outputs are sampled.
module tb_memshare_sched_ctrl;

  localparam int SEQ_W = 3;
  localparam int P     = 3;
  localparam int D     = 2;
  localparam int EW    = SEQ_W + 6;

  logic             sys_clk;
  logic             rst;
  logic             rqst_valid_i;
  logic             rqst_ready_o;
  logic [SEQ_W-1:0] rqst_seq_num_i;
  logic             stall_i;
  logic             abort_i;
  logic             scu_memShare_busy_o;
  logic             rfmu_rd_o;
  logic             pipeCycle_begin_o;
  logic [SEQ_W-1:0] seq_idx_o;
  logic             last_seq_o;
  logic             done_o;

  int vectors;
  int miscompares;
  logic [EW-1:0] sb_q[$];
  string         tag_q[$];

  memshare_sched_ctrl #(
    .MAX_SEQ(4), .PIPE_CYCLE_LEN(P), .DRAIN_LAT(D), .SEQ_W(SEQ_W)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .rqst_valid_i(rqst_valid_i),
    .rqst_ready_o(rqst_ready_o),
    .rqst_seq_num_i(rqst_seq_num_i),
    .stall_i(stall_i),
    .abort_i(abort_i),
    .scu_memShare_busy_o(scu_memShare_busy_o),
    .rfmu_rd_o(rfmu_rd_o),
    .pipeCycle_begin_o(pipeCycle_begin_o),
    .seq_idx_o(seq_idx_o),
    .last_seq_o(last_seq_o),
    .done_o(done_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Vector layout: {ready, busy, rfmu_rd, pipeCycle_begin, seq_idx, last_seq, done}
  function automatic logic [EW-1:0] mk(bit rdy, bit bsy, bit rd, bit pcb, int idx, bit lst, bit dn);
    logic [SEQ_W-1:0] i3;
    i3 = idx[SEQ_W-1:0];
    return {rdy, bsy, rd, pcb, i3, lst, dn};
  endfunction

  // Expected outputs k cycles after an unstalled accept with N sequences.
  function automatic logic [EW-1:0] exp_run(int n, int k);
    int last_alloc;
    int last_drain;
    int j;
    last_alloc = 1 + n * P;
    last_drain = last_alloc + D;
    if (k == 0) return mk(1, 0, 0, 0, 0, 0, 0);
    if (k == 1) return mk(0, 1, 1, 0, 0, 0, 0);
    if (k <= last_alloc) begin
      j = k - 2;
      return mk(0, 1, 0, (j % P) == 0, j / P, (j / P) == n - 1, 0);
    end
    if (k <= last_drain) return mk(0, 1, 0, 0, 0, 0, 0);
    if (k == last_drain + 1) return mk(1, 0, 0, 0, 0, 0, 1);
    return mk(1, 0, 0, 0, 0, 0, 0);
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cycle(input logic v, input logic [SEQ_W-1:0] sn, input logic st,
                       input logic ab, input logic rs, input logic [EW-1:0] e, input string tag);
    logic [EW-1:0] obs;
    logic [EW-1:0] exp_v;
    string         t;
    rqst_valid_i   = v;
    rqst_seq_num_i = sn;
    stall_i        = st;
    abort_i        = ab;
    rst            = rs;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge sys_clk);
    obs   = {rqst_ready_o, scu_memShare_busy_o, rfmu_rd_o, pipeCycle_begin_o,
             seq_idx_o, last_seq_o, done_o};
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (rdy,bsy,rd,pcb,idx,last,done)", t, obs, exp_v);
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    rqst_valid_i   = 1'b0;
    rqst_seq_num_i = 3'd0;
    stall_i        = 1'b0;
    abort_i        = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;

    // Reset state, then idle with a stray abort that must be ignored
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0), "reset");
    cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "idle_abort");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "idle");

    // Single request N=2: done at T+10
    cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, exp_run(2, 0), "n2_accept");
    for (int k = 1; k <= 11; k++)
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(2, k), $sformatf("n2_k%0d", k));

    // Clamp 0 -> N=1: done at T+7
    cycle(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, 0), "clamp0_accept");
    for (int k = 1; k <= 8; k++)
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, k), $sformatf("clamp0_k%0d", k));

    // Clamp 7 -> N=4: done at T+16; stall asserted in SHIFT_GEN and DRAIN is ignored
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, exp_run(4, 0), "clamp7_accept");
    for (int k = 1; k <= 17; k++)
      cycle(1'b0, 3'd0, (k == 1 || k == 14 || k == 15), 1'b0, 1'b0, exp_run(4, k),
            $sformatf("clamp7_k%0d", k));

    // Stall N=1 at T+2,T+3: pipeCycle_begin only at T+4, done at T+9
    cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, exp_run(1, 0), "stall_accept");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, 1), "stall_k1");
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 0), "stall_k2");
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 0), "stall_k3");
    for (int k = 4; k <= 10; k++)
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, k - 2), $sformatf("stall_k%0d", k));

    // Abort at T+3 in ALLOC, new request accepted at T+4 runs normally
    cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, exp_run(2, 0), "abort_accept");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(2, 1), "abort_k1");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(2, 2), "abort_k2");
    cycle(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, exp_run(2, 3), "abort_k3");
    cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "abort_k4_reaccept");
    for (int k = 1; k <= 8; k++)
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, k), $sformatf("after_abort_k%0d", k));

    // Back-to-back with valid held: second accept coincides with done
    cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, exp_run(1, 0), "b2b_accept1");
    for (int k = 1; k <= 6; k++)
      cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, exp_run(1, k), $sformatf("b2b_first_k%0d", k));
    cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, exp_run(1, 7), "b2b_accept2_done");
    for (int k = 1; k <= 8; k++)
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, k), $sformatf("b2b_second_k%0d", k));

    // Reset pulsed during DRAIN: reset outputs next cycle and no done
    cycle(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, exp_run(1, 0), "rst_accept");
    for (int k = 1; k <= 4; k++)
      cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, exp_run(1, k), $sformatf("rst_k%0d", k));
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, exp_run(1, 5), "rst_k5_drain");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "rst_k6");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "rst_k7_nodone");
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0), "rst_k8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
